// File: rtl/clock_mode_ctrl.sv
// rtl/clock_mode_ctrl.sv - alarm-clock mode/position controller with debounced buttons,
// 1 s tick divider, setup/alarm increment pulses, blink and alarm ring FSM.
module clock_mode_ctrl #(
  parameter int P_SEC_DIV = 50000000,
  parameter int P_DEB_DIV = 500000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_sw0,
  input  logic       i_sw1,
  input  logic       i_sw2,
  input  logic       i_sec_max,
  input  logic       i_min_max,
  input  logic       i_alarm_match,
  output logic       o_sec_inc,
  output logic       o_min_inc,
  output logic       o_hour_inc,
  output logic       o_al_sec_inc,
  output logic       o_al_min_inc,
  output logic       o_al_hour_inc,
  output logic [1:0] o_mode,
  output logic [1:0] o_position,
  output logic       o_blink,
  output logic       o_alarm_en,
  output logic       o_buzz
);

  localparam int SEC_W = (P_SEC_DIV > 1) ? $clog2(P_SEC_DIV) : 1;
  localparam int DEB_W = (P_DEB_DIV > 1) ? $clog2(P_DEB_DIV) : 1;
  localparam logic [SEC_W-1:0] SEC_MAX  = SEC_W'(P_SEC_DIV - 1);
  localparam logic [SEC_W-1:0] SEC_HALF = SEC_W'(P_SEC_DIV / 2);
  localparam logic [DEB_W-1:0] DEB_MAX  = DEB_W'(P_DEB_DIV - 1);

  localparam logic [1:0] MODE_CLOCK = 2'd0;
  localparam logic [1:0] MODE_SETUP = 2'd1;
  localparam logic [1:0] MODE_ALARM = 2'd2;

  typedef enum logic {AL_IDLE = 1'b0, AL_RING = 1'b1} al_state_e;

  al_state_e        state_q, state_d;
  logic [2:0]       sync1_q, sync2_q, hist_q, hist_d, lvl_q, lvl_d, press_q, press_d;
  logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d;
  logic [SEC_W-1:0] div_q, div_d, blink_cnt_q, blink_cnt_d;
  logic [4:0]       ring_cnt_q, ring_cnt_d;
  logic [1:0]       mode_q, mode_d, pos_q, pos_d, mode_eff;
  logic             alarm_en_q, alarm_en_d, blink_q, blink_d;
  logic [2:0]       inc_q, inc_d, al_inc_q, al_inc_d;
  logic             sample, tick, in_setup, ringing, p0, p1, p2;

  always_comb begin
    deb_cnt_d   = (deb_cnt_q == DEB_MAX) ? '0 : deb_cnt_q + DEB_W'(1);
    sample      = (deb_cnt_q == DEB_MAX);
    hist_d      = sample ? sync2_q : hist_q;
    lvl_d       = lvl_q;
    for (int i = 0; i < 3; i++) begin
      if (sample && sync2_q[i] && hist_q[i])   lvl_d[i] = 1'b1;
      if (sample && !sync2_q[i] && !hist_q[i]) lvl_d[i] = 1'b0;
    end
    press_d     = lvl_d & ~lvl_q;

    mode_eff    = (mode_q == 2'd3) ? MODE_CLOCK : mode_q;
    in_setup    = (mode_eff == MODE_SETUP);
    ringing     = (state_q == AL_RING);
    // A press while ringing only silences the alarm.
    p0          = press_q[0] && !ringing;
    p1          = press_q[1] && !press_q[0] && !ringing;
    p2          = press_q[2] && !press_q[1] && !press_q[0] && !ringing;

    tick        = !in_setup && (div_q == SEC_MAX);
    div_d       = (in_setup || div_q == SEC_MAX) ? '0 : div_q + SEC_W'(1);
    blink_cnt_d = (blink_cnt_q == SEC_MAX) ? '0 : blink_cnt_q + SEC_W'(1);

    mode_d      = mode_q;
    pos_d       = pos_q;
    if (p0) begin
      mode_d = (mode_eff == MODE_ALARM) ? MODE_CLOCK : mode_eff + 2'd1;
      pos_d  = 2'd0;
    end else if (p1 && mode_eff != MODE_CLOCK) begin
      pos_d  = (pos_q >= 2'd2) ? 2'd0 : pos_q + 2'd1;
    end
    blink_d     = (mode_d == MODE_CLOCK) || (blink_cnt_d < SEC_HALF);

    inc_d[0]    = tick || (in_setup && p2 && pos_q == 2'd0);
    inc_d[1]    = (tick && i_sec_max) || (in_setup && p2 && pos_q == 2'd1);
    inc_d[2]    = (tick && i_sec_max && i_min_max) || (in_setup && p2 && pos_q == 2'd2);
    for (int i = 0; i < 3; i++) begin
      al_inc_d[i] = (mode_eff == MODE_ALARM) && p2 && (pos_q == 2'(i));
    end
    alarm_en_d  = alarm_en_q ^ ((mode_eff == MODE_CLOCK) && p2);

    state_d     = state_q;
    ring_cnt_d  = '0;
    case (state_q)
      AL_IDLE: begin
        if (tick && mode_eff == MODE_CLOCK && alarm_en_q && i_alarm_match) state_d = AL_RING;
      end
      AL_RING: begin
        ring_cnt_d = tick ? ring_cnt_q + 5'd1 : ring_cnt_q;
        if ((|press_q) || !alarm_en_q || (tick && ring_cnt_q == 5'd29)) state_d = AL_IDLE;
      end
      default: state_d = AL_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= AL_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      hist_q      <= '0;
      lvl_q       <= '0;
      press_q     <= '0;
      deb_cnt_q   <= '0;
      div_q       <= '0;
      blink_cnt_q <= '0;
      ring_cnt_q  <= '0;
      mode_q      <= MODE_CLOCK;
      pos_q       <= 2'd0;
      alarm_en_q  <= 1'b0;
      blink_q     <= 1'b1;
      inc_q       <= '0;
      al_inc_q    <= '0;
    end else begin
      sync1_q     <= {i_sw2, i_sw1, i_sw0};
      sync2_q     <= sync1_q;
      hist_q      <= hist_d;
      lvl_q       <= lvl_d;
      press_q     <= press_d;
      deb_cnt_q   <= deb_cnt_d;
      div_q       <= div_d;
      blink_cnt_q <= blink_cnt_d;
      ring_cnt_q  <= ring_cnt_d;
      mode_q      <= mode_d;
      pos_q       <= pos_d;
      alarm_en_q  <= alarm_en_d;
      blink_q     <= blink_d;
      inc_q       <= inc_d;
      al_inc_q    <= al_inc_d;
    end
  end

  assign o_sec_inc     = inc_q[0];
  assign o_min_inc     = inc_q[1];
  assign o_hour_inc    = inc_q[2];
  assign o_al_sec_inc  = al_inc_q[0];
  assign o_al_min_inc  = al_inc_q[1];
  assign o_al_hour_inc = al_inc_q[2];
  assign o_mode        = mode_q;
  assign o_position    = pos_q;
  assign o_blink       = blink_q;
  assign o_alarm_en    = alarm_en_q;
  assign o_buzz        = (state_q == AL_RING);

endmodule
